fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//  Instruction fetch/PC stage of the single-cycle RV32I core; drives instruction memory and feeds instr to control_unit (im_data).
//  Owns the PC register, applies control_unit's PCsrc plus its own JAL decode to form next PC.
//  Sequences fetch/execute via FSM; halts on EBREAK or misaligned target.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  NOP_INSTR 32'h0000_0013  instr value held while no valid fetch (ADDI x0,x0,0)
// PORTS
//  clk         in   1   core clock, rising edge
//  rst_n       in   1   reset, asynchronous assert, active-low
//  run         in   1   start strobe; sampled in IDLE only
//  im_req      out  1   instruction memory request
//  im_addr     out  32  fetch address (= pc)
//  im_ack      in   1   memory accepted req; im_rdata valid same cycle
//  im_rdata    in   32  fetched instruction
//  PCsrc       in   2   from control_unit: 0 seq, 1 branch taken, 2 JALR, 3 reserved
//  alu_result  in   32  rs1+imm from ALU, JALR target
//  instr       out  32  held instruction -> control_unit im_data / datapath
//  pc          out  32  PC of instr
//  pc_plus4    out  32  pc+4 (JAL/JALR link value)
//  instr_valid out  1   one-cycle commit strobe: datapath writes regs/mem this cycle
//  halted      out  1   sticky: EBREAK retired
//  misaligned  out  1   sticky: next PC had [1:0]!=0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, instr=NOP_INSTR, im_req=0, instr_valid=0, halted=0, misaligned=0.
//  FSM states IDLE, REQ, EXEC, HALT:
//   IDLE: run=1 -> REQ; else stay.
//   REQ: im_req=1, im_addr=pc; im_ack=1 -> latch instr<=im_rdata, ->EXEC. im_req held stable until ack.
//   EXEC: instr_valid=1 for exactly this cycle; on clk edge:
//     opcode==7'b1110011 -> HALT, halted<=1, pc unchanged.
//     next_pc[1:0]!=0 -> HALT, misaligned<=1, pc unchanged.
//     else pc<=next_pc, ->REQ.
//   HALT: terminal until reset; im_req=0, instr_valid=0; run ignored.
//  im_ack ignored outside REQ. Zero-wait memory => 2 cycles/instruction (REQ,EXEC).
//  next_pc (combinational from instr,pc, mod 2^32, wrap silently):
//   PCsrc=1 -> pc + B-imm {sext i[31],i[7],i[30:25],i[11:8],0}
//   PCsrc=2 -> {alu_result[31:1],1'b0}
//   PCsrc=0 & opcode==7'b1101111 (JAL) -> pc + J-imm {sext i[31],i[19:12],i[20],i[30:21],0}
//   PCsrc=0 otherwise, or PCsrc=3 -> pc+4
//  PCsrc/alu_result are sampled only in EXEC; PCsrc priority over JAL decode.
//  pc_plus4 = pc+4 always (wraps 32'hFFFF_FFFC -> 0).
//  instr holds last fetched value in REQ/HALT (not NOP) so control_unit outputs stay stable.
//  Reset mid-REQ: im_req drops immediately (async); no partial latch.
// STRUCTURE
//  Shared package core_pkg: state enum, opcode localparams (OP_JAL, OP_JALR, OP_BRANCH,
//   OP_EBREAK, ...) shared with control_unit, PCSRC_* codes, NOP_INSTR.
//  Sub-module next_pc_gen: combinational B/J immediate extraction + next_pc mux; FSM and
//   registers stay in fetch_unit.
// TESTING
//  Reset, run=1, ack every cycle, imem NOP x3 -> im_addr 0,4,8; instr_valid pulses every 2nd cycle.
//  EXEC JAL 32'h0100006F at pc=0x10, PCsrc=0 -> next im_addr 0x20; pc_plus4=0x14 during EXEC.
//  BEQ 32'hFE000EE3 at pc=0x40, PCsrc=1 -> next im_addr 0x3C; PCsrc=0 -> 0x44.
//  JALR alu_result=0x0000_1235, PCsrc=2 -> next im_addr 0x1234; alu_result=0x1236 -> misaligned=1, HALT, im_req stays 0.
//  EBREAK 32'h00100073 -> halted=1 after EXEC, pc frozen, im_req=0 with run=1 held 10 cycles.
//  im_ack held low 5 cycles in REQ -> im_req/im_addr stable, instr_valid=0; rst_n low mid-REQ -> im_req=0 same cycle, pc=RESET_PC.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared fetch/control definitions: FSM states, opcodes, PC-source codes and the NOP encoding.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EXEC = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_EBREAK = 7'b1110011;

  localparam logic [1:0] PCSRC_SEQ    = 2'd0;
  localparam logic [1:0] PCSRC_BRANCH = 2'd1;
  localparam logic [1:0] PCSRC_JALR   = 2'd2;
  localparam logic [1:0] PCSRC_RSVD   = 2'd3;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;
  localparam logic [31:0] PC_RESET_VAL = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_unit_if;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ack;
  logic [31:0] im_rdata;

  modport master (output im_req, output im_addr, input im_ack, input im_rdata);
  modport slave  (input im_req, input im_addr, output im_ack, output im_rdata);
endinterface

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC generation: B/J immediate extraction and PC-source mux.
module fetch_unit_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] pc_plus4;

  assign imm_b = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_j = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
  assign pc_plus4 = pc_i + 32'd4;

  // control_unit's PC source wins over the local JAL decode
  always_comb begin
    next_pc_o = pc_plus4;
    case (pcsrc_i)
      PCSRC_BRANCH: next_pc_o = pc_i + imm_b;
      PCSRC_JALR:   next_pc_o = alu_result_i & 32'hFFFF_FFFE;
      PCSRC_SEQ: begin
        if (instr_i[6:0] == OP_JAL) next_pc_o = pc_i + imm_j;
      end
      default:      next_pc_o = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch/PC stage: owns PC and instruction registers, sequences REQ/EXEC per instruction.
// state | meaning
// IDLE  | waiting for run strobe
// REQ   | im_req high at pc until im_ack latches the instruction
// EXEC  | instr_valid commit cycle; PC advances or halts
// HALT  | terminal after EBREAK or misaligned target, until reset
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = PC_RESET_VAL,
  parameter logic [31:0] NOP_INSTR = INSTR_NOP
) (
  input  logic        clk,
  input  logic        rst_n,
  fetch_unit_if.master imem,
  input  logic        run_i,
  input  logic [1:0]  pcsrc_i,
  input  logic [31:0] alu_result_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o,
  output logic        instr_valid_o,
  output logic        halted_o,
  output logic        misaligned_o
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         halted_q, halted_d;
  logic         misaligned_q, misaligned_d;
  logic         im_req;
  logic         instr_valid;
  logic [31:0]  next_pc;

  fetch_unit_next_pc u_next_pc (
    .instr_i      (instr_q),
    .pc_i         (pc_q),
    .pcsrc_i      (pcsrc_i),
    .alu_result_i (alu_result_i),
    .next_pc_o    (next_pc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      halted_q     <= halted_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    halted_d     = halted_q;
    misaligned_d = misaligned_q;
    im_req       = 1'b0;
    instr_valid  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_REQ;
      end
      ST_REQ: begin
        im_req = 1'b1;
        if (imem.im_ack) begin
          instr_d = imem.im_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        instr_valid = 1'b1;
        if (instr_q[6:0] == OP_EBREAK) begin
          halted_d = 1'b1;
          state_d  = ST_HALT;
        end else if (next_pc[1:0] != 2'b00) begin
          misaligned_d = 1'b1;
          state_d      = ST_HALT;
        end else begin
          pc_d    = next_pc;
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  assign imem.im_req   = im_req;
  assign imem.im_addr  = pc_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign pc_plus4_o    = pc_q + 32'd4;
  assign instr_valid_o = instr_valid;
  assign halted_o      = halted_q;
  assign misaligned_o  = misaligned_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, JAL, branch, JALR, halts, stall and async reset.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        run = 1'b0;
  logic        ack = 1'b1;
  logic [1:0]  pcsrc;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] sel_pc = 32'hFFFF_FFF0;
  logic [1:0]  sel_val = 2'd0;
  logic [31:0] instr, pc, pc_plus4;
  logic        instr_valid, halted, misaligned;
  logic [31:0] imem [0:2047];

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus ();
  assign bus.im_ack   = ack;
  assign bus.im_rdata = imem[bus.im_addr[12:2]];
  assign pcsrc        = (pc == sel_pc) ? sel_val : 2'd0;

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem          (bus),
    .run_i         (run),
    .pcsrc_i       (pcsrc),
    .alu_result_i  (alu_result),
    .instr_o       (instr),
    .pc_o          (pc),
    .pc_plus4_o    (pc_plus4),
    .instr_valid_o (instr_valid),
    .halted_o      (halted),
    .misaligned_o  (misaligned)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_mem();
    for (int i = 0; i < 2048; i++) imem[i] = NOP;
    sel_pc     = 32'hFFFF_FFF0;
    sel_val    = 2'd0;
    alu_result = 32'h0;
    ack        = 1'b1;
  endtask

  task automatic do_reset();
    run   = 1'b0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic start_run();
    run = 1'b1;
    step();
    run = 1'b0;
  endtask

  // bounded wait for the EXEC cycle of the instruction at target
  task automatic wait_exec(input logic [31:0] target);
    for (int i = 0; i < 200; i++) begin
      if (instr_valid === 1'b1 && pc === target) return;
      step();
    end
    n_total++;
    $display("FAIL wait_exec: timed out, pc=%h expected EXEC at %h", pc, target);
  endtask

  task automatic test_reset();
    init_mem();
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.im_req !== 1'b0) $display("FAIL rst_im_req: got %b expected 0", bus.im_req); else n_pass++;
    n_total++; if (pc !== 32'h0) $display("FAIL rst_pc: got %h expected 00000000", pc); else n_pass++;
    n_total++; if (instr !== NOP) $display("FAIL rst_instr: got %h expected %h", instr, NOP); else n_pass++;
    n_total++; if (instr_valid !== 1'b0) $display("FAIL rst_valid: got %b expected 0", instr_valid); else n_pass++;
    n_total++; if ({halted, misaligned} !== 2'b00) $display("FAIL rst_flags: got %b expected 00", {halted, misaligned}); else n_pass++;
    rst_n = 1'b1;
    step();
    n_total++; if (bus.im_req !== 1'b0) $display("FAIL idle_no_req: got %b expected 0", bus.im_req); else n_pass++;
  endtask

  task automatic test_sequential();
    init_mem();
    do_reset();
    start_run();
    for (int i = 0; i < 3; i++) begin
      n_total++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'(4 * i) || instr_valid !== 1'b0)
        $display("FAIL seq_req%0d: got req=%b addr=%h valid=%b expected 1 %h 0", i, bus.im_req, bus.im_addr, instr_valid, 32'(4 * i));
      else n_pass++;
      step();
      n_total++; if (instr_valid !== 1'b1 || pc !== 32'(4 * i) || bus.im_req !== 1'b0)
        $display("FAIL seq_exec%0d: got valid=%b pc=%h req=%b expected 1 %h 0", i, instr_valid, pc, bus.im_req, 32'(4 * i));
      else n_pass++;
      step();
    end
  endtask

  task automatic test_jal();
    init_mem();
    imem[32'h10 >> 2] = 32'h0100_006F;
    do_reset();
    start_run();
    wait_exec(32'h10);
    n_total++; if (instr !== 32'h0100_006F) $display("FAIL jal_instr: got %h expected 0100006f", instr); else n_pass++;
    n_total++; if (pc_plus4 !== 32'h14) $display("FAIL jal_pc_plus4: got %h expected 00000014", pc_plus4); else n_pass++;
    step();
    n_total++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h20) $display("FAIL jal_target: got req=%b addr=%h expected 1 00000020", bus.im_req, bus.im_addr); else n_pass++;
  endtask

  task automatic test_branch();
    init_mem();
    imem[32'h40 >> 2] = 32'hFE00_0EE3;
    sel_pc  = 32'h40;
    sel_val = 2'd1;
    do_reset();
    start_run();
    wait_exec(32'h40);
    step();
    n_total++; if (bus.im_addr !== 32'h3C) $display("FAIL beq_taken: got %h expected 0000003c", bus.im_addr); else n_pass++;
    init_mem();
    imem[32'h40 >> 2] = 32'hFE00_0EE3;
    do_reset();
    start_run();
    wait_exec(32'h40);
    step();
    n_total++; if (bus.im_addr !== 32'h44) $display("FAIL beq_not_taken: got %h expected 00000044", bus.im_addr); else n_pass++;
  endtask

  task automatic test_jalr();
    init_mem();
    imem[0]    = 32'h0000_80E7;
    sel_pc     = 32'h0;
    sel_val    = 2'd2;
    alu_result = 32'h0000_1235;
    do_reset();
    start_run();
    wait_exec(32'h0);
    step();
    n_total++; if (bus.im_addr !== 32'h1234 || misaligned !== 1'b0) $display("FAIL jalr_target: got addr=%h mis=%b expected 00001234 0", bus.im_addr, misaligned); else n_pass++;
    init_mem();
    imem[0]    = 32'h0000_80E7;
    sel_pc     = 32'h0;
    sel_val    = 2'd2;
    alu_result = 32'h0000_1236;
    do_reset();
    start_run();
    wait_exec(32'h0);
    step();
    n_total++; if (misaligned !== 1'b1 || halted !== 1'b0) $display("FAIL jalr_misaligned: got mis=%b halt=%b expected 1 0", misaligned, halted); else n_pass++;
    n_total++; if (pc !== 32'h0) $display("FAIL jalr_pc_frozen: got %h expected 00000000", pc); else n_pass++;
    run = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (bus.im_req !== 1'b0 || instr_valid !== 1'b0) $display("FAIL mis_halt_req%0d: got req=%b valid=%b expected 0 0", i, bus.im_req, instr_valid); else n_pass++;
      step();
    end
    run = 1'b0;
  endtask

  task automatic test_ebreak();
    init_mem();
    imem[32'h8 >> 2] = 32'h0010_0073;
    do_reset();
    start_run();
    wait_exec(32'h8);
    n_total++; if (halted !== 1'b0) $display("FAIL ebreak_early_halt: got %b expected 0", halted); else n_pass++;
    step();
    n_total++; if (halted !== 1'b1 || misaligned !== 1'b0) $display("FAIL ebreak_halted: got halt=%b mis=%b expected 1 0", halted, misaligned); else n_pass++;
    run = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_total++; if (bus.im_req !== 1'b0 || pc !== 32'h8 || instr_valid !== 1'b0)
        $display("FAIL ebreak_hold%0d: got req=%b pc=%h valid=%b expected 0 00000008 0", i, bus.im_req, pc, instr_valid);
      else n_pass++;
      step();
    end
    run = 1'b0;
    n_total++; if (instr !== 32'h0010_0073) $display("FAIL ebreak_instr_held: got %h expected 00100073", instr); else n_pass++;
  endtask

  task automatic test_stall_and_reset();
    init_mem();
    imem[0] = 32'h0000_0093;
    do_reset();
    ack = 1'b0;
    start_run();
    for (int i = 0; i < 5; i++) begin
      n_total++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h0 || instr_valid !== 1'b0)
        $display("FAIL stall%0d: got req=%b addr=%h valid=%b expected 1 00000000 0", i, bus.im_req, bus.im_addr, instr_valid);
      else n_pass++;
      step();
    end
    n_total++; if (instr !== NOP) $display("FAIL stall_no_latch: got %h expected %h", instr, NOP); else n_pass++;
    ack = 1'b1;
    step();
    n_total++; if (instr_valid !== 1'b1 || instr !== 32'h0000_0093) $display("FAIL stall_release: got valid=%b instr=%h expected 1 00000093", instr_valid, instr); else n_pass++;
    ack = 1'b0;
    step();
    n_total++; if (bus.im_req !== 1'b1 || bus.im_addr !== 32'h4) $display("FAIL stall_req2: got req=%b addr=%h expected 1 00000004", bus.im_req, bus.im_addr); else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++; if (bus.im_req !== 1'b0) $display("FAIL async_rst_req: got %b expected 0", bus.im_req); else n_pass++;
    n_total++; if (pc !== 32'h0 || instr !== NOP) $display("FAIL async_rst_pc: got pc=%h instr=%h expected 00000000 %h", pc, instr, NOP); else n_pass++;
    step();
    rst_n = 1'b1;
    ack   = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_jal();
    test_branch();
    test_jalr();
    test_ebreak();
    test_stall_and_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
